// File: rtl/program_sequencer_if.sv
// program_sequencer_if: program load, run control and processor-side signals of program_sequencer
interface program_sequencer_if #(parameter int ADDR_W = 4);
  logic WrEn, Start, Stop, Consumed, Done, STEP, Busy, Halted, Err;
  logic [9:0] WrData, DOUT;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W:0] Len;
`ifdef SEQ_SINGLE_STEP_EN
  logic StepReq;
  modport master(input WrEn, WrData, Start, Stop, Consumed, Done, StepReq,
                 output DOUT, STEP, PC, Len, Busy, Halted, Err);
  modport slave(output WrEn, WrData, Start, Stop, Consumed, Done, StepReq,
                input DOUT, STEP, PC, Len, Busy, Halted, Err);
`else
  modport master(input WrEn, WrData, Start, Stop, Consumed, Done,
                 output DOUT, STEP, PC, Len, Busy, Halted, Err);
  modport slave(output WrEn, WrData, Start, Stop, Consumed, Done,
                input DOUT, STEP, PC, Len, Busy, Halted, Err);
`endif
endinterface

// File: rtl/program_sequencer.sv
// program_sequencer: stores a short program and feeds it to the 10-bit processor with paced STEP pulses.
// SEQ_SINGLE_STEP_EN adds StepReq: once the gap expires, each STEP waits for a StepReq rising edge.
module program_sequencer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int GAP     = 3,
  parameter int TIMEOUT = 64
) (
  input logic CLK50,
  input logic Clr,
  program_sequencer_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, DRAIN = 3'd3, HALT = 3'd4;
  localparam int GW = $clog2(GAP + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [9:0] mem [DEPTH];
  logic [2:0] state_q, state_d;
  logic [ADDR_W:0] pc_q, pc_d, len_q, len_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0] dout_q, dout_d, word;
  logic step_q, step_d, err_q, err_d, busy_q, busy_d, halted_q, halted_d, we, full, go, run;
`ifdef SEQ_SINGLE_STEP_EN
  logic req_q;
  always_ff @(posedge CLK50) req_q <= Clr ? 1'b0 : bus.StepReq;
  assign go = bus.StepReq & ~req_q;
`else
  assign go = 1'b1;
`endif
  assign full = len_q == (ADDR_W+1)'(DEPTH);
  assign we = bus.WrEn && state_q == IDLE && !full;
  assign run = state_q == ISSUE || state_q == WAIT || state_q == DRAIN;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    len_d = len_q + (ADDR_W+1)'(we);
    gap_d = gap_q;
    cnt_d = cnt_q;
    step_d = 1'b0;
    err_d = err_q | (bus.WrEn && state_q == IDLE && full);
    case (state_q)
      IDLE, HALT: if (bus.Start && !bus.Stop && len_d != '0) begin
        state_d = ISSUE;
        pc_d = '0;
        step_d = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
        gap_d = GW'(GAP - 1);
        pc_d = pc_q + (ADDR_W+1)'(bus.Consumed);
      end
      WAIT: if (bus.Done && pc_q == len_q) state_d = HALT;
        else if (gap_q != '0) gap_d = gap_q - GW'(1);
        else if (go) begin
          state_d = pc_q == len_q ? DRAIN : ISSUE;
          step_d = 1'b1;
          cnt_d = '0;
        end
      DRAIN: if (bus.Done) state_d = HALT;
        else if (step_q) begin
          cnt_d = cnt_q + CW'(1);
          gap_d = GW'(GAP - 1);
        end
        else if (gap_q != '0) gap_d = gap_q - GW'(1);
        else if (go) begin
          state_d = cnt_q == CW'(TIMEOUT) ? HALT : DRAIN;
          err_d = err_q | (cnt_q == CW'(TIMEOUT));
          step_d = cnt_q != CW'(TIMEOUT);
        end
      default: state_d = IDLE;
    endcase
    if (bus.Stop && run) begin
      state_d = IDLE;
      pc_d = pc_q;
      step_d = 1'b0;
      err_d = err_q;
    end
    // a word written in the same cycle as Start must reach DOUT without a memory round trip
    word = (we && len_q == pc_d) ? bus.WrData : mem[pc_d[ADDR_W-1:0]];
    dout_d = ((state_d == ISSUE || state_d == WAIT) && pc_d < len_d) ? word : '0;
    busy_d = state_d == ISSUE || state_d == WAIT || state_d == DRAIN;
    halted_d = state_d == HALT;
  end
  always_ff @(posedge CLK50) if (we && !Clr) mem[len_q[ADDR_W-1:0]] <= bus.WrData;
  always_ff @(posedge CLK50) begin
    if (Clr) begin
      state_q <= IDLE;
      pc_q <= '0;
      len_q <= '0;
      gap_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
      step_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      len_q <= len_d;
      gap_q <= gap_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      step_q <= step_d;
      err_q <= err_d;
      busy_q <= busy_d;
      halted_q <= halted_d;
    end
  end
  assign bus.DOUT = dout_q;
  assign bus.STEP = step_q;
  assign bus.PC = pc_q[ADDR_W-1:0];
  assign bus.Len = len_q;
  assign bus.Busy = busy_q;
  assign bus.Halted = halted_q;
  assign bus.Err = err_q;
endmodule
